rst_req_ctrl: RTL and testbench
===============================

Name: rst_req_ctrl

Overview:
- Upstream request stage for the per-domain asynchronous output-reset generator, clocked on the same reference clock.
- Converts a one-cycle software or CSR reset request into a level reset-request (arst_req_o) held for a programmable number of cycles.
- Monitors the downstream active-low domain reset (fed back asynchronously) and reports completion or timeout.
- One instance per reset domain.

Parameters:
- HOLD_W, 8, width of hold_cycles_i.
- TIMEOUT, 512, max ref_clk_i cycles to wait for downstream reset assertion or release. Must exceed the downstream release delay (128) plus sync latency.
- SYNC_STAGES, 2, flops in the feedback synchronizer (min 2).

Ports:
- ref_clk_i  input  1  reference clock; all state on rising edge.
- arst_i  input  1  asynchronous active-high reset; asserts immediately, release is not synchronized internally.
- req_i  input  1  reset request pulse; sampled every cycle.
- hold_cycles_i  input  HOLD_W  assertion length; captured when a request is accepted.
- arst_n_fb_i  input  1  downstream active-low domain reset, asynchronous to ref_clk_i.
- arst_req_o  output  1  registered level request to the downstream reset generator.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle pulse when the downstream reset is observed released.
- timeout_o  output  1  sticky error flag.
- drop_o  output  1  one-cycle pulse when req_i is ignored because the block is busy.

Behaviour:
- Reset values (arst_i=1): state=IDLE; arst_req_o=0, busy_o=0, done_o=0, timeout_o=0, drop_o=0; all counters 0; synchronizer flops 0 (domain treated as in reset).
- Feedback: arst_n_fb_i passes through a SYNC_STAGES flop chain to give fb_s. No other logic touches arst_n_fb_i.
- IDLE:
  - req_i=1 → next cycle state=ASSERT, arst_req_o=1.
  - On entry, hold_cnt loads hold_cycles_i, with 0 treated as 1.
  - seen_low clears, tmo_cnt clears, timeout_o clears.
- ASSERT:
  - arst_req_o=1.
  - hold_cnt decrements each cycle while nonzero.
  - seen_low sets on any cycle with fb_s=0.
  - Exit to RELEASE when hold_cnt has reached 0 and seen_low=1. arst_req_o is therefore high for max(N, cycles until fb_s low observed), where N=hold value.
  - tmo_cnt counts only while hold_cnt=0 and seen_low=0. On reaching TIMEOUT: timeout_o=1, go IDLE.
- RELEASE:
  - arst_req_o=0 on the entry cycle; tmo_cnt cleared on entry.
  - fb_s=1 → done_o=1 for exactly one cycle, next state IDLE.
  - tmo_cnt reaching TIMEOUT with fb_s still 0 → timeout_o=1, no done_o, go IDLE.
- Latency, nominal path: req_i at cycle 0 → arst_req_o high cycles 1..N. This assumes fb_s went low by cycle N, which happens when N ≥ SYNC_STAGES+1.
- timeout_o: stays 1 until the next accepted request.
- Simultaneous events:
  - req_i while busy_o=1 → ignored; drop_o=1 the next cycle. Includes the cycle done_o is asserted; done has priority and the request is dropped.
  - req_i in IDLE on the same cycle timeout_o is set → cannot occur, because timeout transitions leave from ASSERT or RELEASE.
- Mid-operation arst_i: everything returns to reset values immediately, arst_req_o drops asynchronously, and no done_o is generated.
- Width rules:
  - hold_cnt is HOLD_W bits.
  - tmo_cnt is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
  - Max hold is 2^HOLD_W−1 cycles; no wrap.

Test Plan:
- Nominal: hold_cycles_i=10, req_i pulse at cycle 0, fb low from cycle 2, fb high at cycle 150 → arst_req_o high cycles 1..10; done_o single pulse 2 cycles after fb rises (cycle 152); busy_o falls the following cycle.
- Zero hold: hold_cycles_i=0, fb falls 1 cycle after arst_req_o → arst_req_o stays high until seen_low plus 1 (≈4 cycles, not 1); done_o after fb release.
- Dropped request: req_i pulses at cycles 0 and 5 with hold=20 → single 20-cycle assertion; drop_o pulse at cycle 6; exactly one done_o.
- Release timeout: fb never returns high, TIMEOUT=512 → no done_o; timeout_o=1 exactly 512 cycles after RELEASE entry; the next req_i clears timeout_o and completes normally.
- Assert timeout: fb held high permanently, hold=5 → arst_req_o high 5+512 cycles, then timeout_o=1 and arst_req_o=0.
- Async reset mid-ASSERT: arst_i pulsed at hold cycle 3 of 10 → arst_req_o=0 within the same cycle; all outputs at reset values; no done_o or drop_o afterwards.

Source files
------------

// File: rtl/rst_req_ctrl.sv
// Reset-request front end for one output-reset domain: turns a request pulse into a
// held reset request, then watches the synchronized domain reset for completion or timeout.
module rst_req_ctrl #(
    parameter int unsigned HOLD_W      = 8,
    parameter int unsigned TIMEOUT     = 512,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              ref_clk_i,
    input  logic              arst_i,
    input  logic              req_i,
    input  logic [HOLD_W-1:0] hold_cycles_i,
    input  logic              arst_n_fb_i,
    output logic              arst_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              drop_o,
    output logic [1:0]        dbg_state_o
);

    localparam int unsigned       TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   seen_low_q, seen_low_d;
    logic                   timeout_q, timeout_d;
    logic                   arst_req_q, arst_req_d;
    logic                   drop_q, drop_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   fb_s;
    logic [HOLD_W-1:0]      hold_dec;
    logic [TMO_W-1:0]       tmo_inc;
    logic                   seen_now;

    // Cleared to 0 on reset so the domain is assumed to be in reset until proven otherwise.
    always_ff @(posedge ref_clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], arst_n_fb_i};
        end
    end

    assign fb_s     = sync_q[SYNC_STAGES-1];
    assign hold_dec = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
    assign tmo_inc  = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + TMO_W'(1);
    assign seen_now = seen_low_q | ~fb_s;

    always_ff @(posedge ref_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            tmo_q      <= '0;
            seen_low_q <= 1'b0;
            timeout_q  <= 1'b0;
            arst_req_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
            seen_low_q <= seen_low_d;
            timeout_q  <= timeout_d;
            arst_req_q <= arst_req_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tmo_d      = tmo_q;
        seen_low_d = seen_low_q;
        timeout_d  = timeout_q;
        arst_req_d = arst_req_q;
        drop_d     = req_i & (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                arst_req_d = 1'b0;
                if (req_i) begin
                    state_d    = ST_ASSERT;
                    arst_req_d = 1'b1;
                    hold_d     = (hold_cycles_i == '0) ? HOLD_W'(1) : hold_cycles_i;
                    seen_low_d = 1'b0;
                    tmo_d      = '0;
                    timeout_d  = 1'b0;
                end
            end

            ST_ASSERT: begin
                arst_req_d = 1'b1;
                hold_d     = hold_dec;
                seen_low_d = seen_now;
                // Decide on next-cycle values so the request drops right after the Nth held cycle.
                if ((hold_dec == '0) && seen_now) begin
                    state_d    = ST_RELEASE;
                    arst_req_d = 1'b0;
                    tmo_d      = '0;
                end else if ((hold_q == '0) && !seen_low_q) begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        state_d    = ST_IDLE;
                        arst_req_d = 1'b0;
                        timeout_d  = 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                arst_req_d = 1'b0;
                if (fb_s) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_MAX) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                arst_req_d = 1'b0;
            end
        endcase
    end

    assign arst_req_o  = arst_req_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_RELEASE) & fb_s;
    assign timeout_o   = timeout_q;
    assign drop_o      = drop_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl: stimulus queues expected output events with their
// cycle numbers; a negedge monitor turns output edges into events and checks them in order.
module tb_rst_req_ctrl;

    localparam int W = 20;

    localparam logic [3:0] EV_REQ_RISE  = 4'd1;
    localparam logic [3:0] EV_REQ_FALL  = 4'd2;
    localparam logic [3:0] EV_DONE      = 4'd3;
    localparam logic [3:0] EV_DROP      = 4'd4;
    localparam logic [3:0] EV_TMO_RISE  = 4'd5;
    localparam logic [3:0] EV_BUSY_FALL = 4'd6;
    localparam logic [3:0] EV_TMO_FALL  = 4'd7;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic       req = 1'b0;
    logic [7:0] hold = 8'd0;
    logic       fb_n = 1'b1;
    logic       arst_req, busy, done, tmo, drop;
    logic [1:0] dbg_state;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    rst_req_ctrl #(.HOLD_W(8), .TIMEOUT(512), .SYNC_STAGES(2)) dut (
        .ref_clk_i    (clk),
        .arst_i       (arst),
        .req_i        (req),
        .hold_cycles_i(hold),
        .arst_n_fb_i  (fb_n),
        .arst_req_o   (arst_req),
        .busy_o       (busy),
        .done_o       (done),
        .timeout_o    (tmo),
        .drop_o       (drop),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: cycle=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [3:0] k, input int c);
        exp_q.push_back({k, 16'(c)});
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d cycle=%0d", name, got, want, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arst_req"}, {7'd0, arst_req}, 8'd0);
        check({tag, "_busy"},     {7'd0, busy},     8'd0);
        check({tag, "_done"},     {7'd0, done},     8'd0);
        check({tag, "_drop"},     {7'd0, drop},     8'd0);
        check({tag, "_timeout"},  {7'd0, tmo},      8'd0);
        check({tag, "_state"},    {6'd0, dbg_state}, 8'd0);
    endtask

    // scoreboard monitor
    logic p_req = 1'b0, p_busy = 1'b0, p_tmo = 1'b0;

    task automatic observe(input logic [3:0] k);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {k, 16'(cyc)};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected: got kind=%0d cycle=%0d, none pending", k, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL event: got kind=%0d cycle=%0d want kind=%0d cycle=%0d",
                         got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (arst_req && !p_req) observe(EV_REQ_RISE);
        if (!arst_req && p_req) observe(EV_REQ_FALL);
        if (done)               observe(EV_DONE);
        if (drop)               observe(EV_DROP);
        if (tmo && !p_tmo)      observe(EV_TMO_RISE);
        if (!busy && p_busy)    observe(EV_BUSY_FALL);
        if (!tmo && p_tmo)      observe(EV_TMO_FALL);
        p_req  = arst_req;
        p_busy = busy;
        p_tmo  = tmo;
    end

    // stimulus
    initial begin
        int t0;
        int t1;
        @(posedge clk);
        #1;
        go_to(3);
        check_idle_outputs("reset");
        arst = 1'b0;
        go_to(8);
        check_idle_outputs("post_reset");

        // nominal: hold 10, fb low at +2, high at +150
        t0 = cyc;
        expect_ev(EV_REQ_RISE, t0 + 1);
        expect_ev(EV_REQ_FALL, t0 + 11);
        expect_ev(EV_DONE, t0 + 152);
        expect_ev(EV_BUSY_FALL, t0 + 153);
        hold = 8'd10; req = 1'b1;
        go_to(t0 + 1); req = 1'b0;
        go_to(t0 + 2); fb_n = 1'b0;
        go_to(t0 + 150); fb_n = 1'b1;
        go_to(t0 + 170);

        // zero hold behaves as 1, extended until the low feedback is seen
        t0 = cyc;
        expect_ev(EV_REQ_RISE, t0 + 1);
        expect_ev(EV_REQ_FALL, t0 + 5);
        expect_ev(EV_DONE, t0 + 22);
        expect_ev(EV_BUSY_FALL, t0 + 23);
        hold = 8'd0; req = 1'b1;
        go_to(t0 + 1); req = 1'b0;
        go_to(t0 + 2); fb_n = 1'b0;
        go_to(t0 + 20); fb_n = 1'b1;
        go_to(t0 + 40);

        // requests while busy, including on the done cycle, are dropped
        t0 = cyc;
        expect_ev(EV_REQ_RISE, t0 + 1);
        expect_ev(EV_DROP, t0 + 6);
        expect_ev(EV_REQ_FALL, t0 + 21);
        expect_ev(EV_DONE, t0 + 42);
        expect_ev(EV_DROP, t0 + 43);
        expect_ev(EV_BUSY_FALL, t0 + 43);
        hold = 8'd20; req = 1'b1;
        go_to(t0 + 1); req = 1'b0;
        go_to(t0 + 2); fb_n = 1'b0;
        go_to(t0 + 5); req = 1'b1;
        go_to(t0 + 6); req = 1'b0;
        go_to(t0 + 40); fb_n = 1'b1;
        go_to(t0 + 42); req = 1'b1;
        go_to(t0 + 43); req = 1'b0;
        go_to(t0 + 60);

        // release timeout, then a clean request clears the flag
        t0 = cyc;
        expect_ev(EV_REQ_RISE, t0 + 1);
        expect_ev(EV_REQ_FALL, t0 + 5);
        expect_ev(EV_TMO_RISE, t0 + 517);
        expect_ev(EV_BUSY_FALL, t0 + 517);
        hold = 8'd4; req = 1'b1;
        go_to(t0 + 1); req = 1'b0;
        go_to(t0 + 2); fb_n = 1'b0;
        go_to(t0 + 520); fb_n = 1'b1;
        check("tmo_release_sticky", {7'd0, tmo}, 8'd1);
        t1 = t0 + 530;
        go_to(t1);
        expect_ev(EV_REQ_RISE, t1 + 1);
        expect_ev(EV_TMO_FALL, t1 + 1);
        expect_ev(EV_REQ_FALL, t1 + 5);
        expect_ev(EV_DONE, t1 + 32);
        expect_ev(EV_BUSY_FALL, t1 + 33);
        req = 1'b1;
        go_to(t1 + 1); req = 1'b0;
        go_to(t1 + 2); fb_n = 1'b0;
        go_to(t1 + 30); fb_n = 1'b1;
        go_to(t1 + 50);

        // assert timeout: feedback never goes low
        t0 = cyc;
        expect_ev(EV_REQ_RISE, t0 + 1);
        expect_ev(EV_REQ_FALL, t0 + 518);
        expect_ev(EV_TMO_RISE, t0 + 518);
        expect_ev(EV_BUSY_FALL, t0 + 518);
        hold = 8'd5; req = 1'b1;
        go_to(t0 + 1); req = 1'b0;
        go_to(t0 + 530);
        check("tmo_assert_sticky", {7'd0, tmo}, 8'd1);

        // async reset in the middle of ASSERT
        t0 = cyc;
        expect_ev(EV_REQ_RISE, t0 + 1);
        expect_ev(EV_TMO_FALL, t0 + 1);
        expect_ev(EV_REQ_FALL, t0 + 3);
        expect_ev(EV_BUSY_FALL, t0 + 3);
        hold = 8'd10; req = 1'b1;
        go_to(t0 + 1); req = 1'b0;
        go_to(t0 + 2); fb_n = 1'b0;
        go_to(t0 + 3);
        check("pre_arst_req", {7'd0, arst_req}, 8'd1);
        arst = 1'b1;
        #1;
        check_idle_outputs("async");
        go_to(t0 + 4); arst = 1'b0;
        go_to(t0 + 6); fb_n = 1'b1;
        go_to(t0 + 60);
        check_idle_outputs("final");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL events_pending: got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
